matmul_stream_host: RTL

Host-side driver for the 2x2 signed matrix multiplier core. It accepts matrix elements one at a time over a valid/ready stream and packs them into the core's A and B operand bytes. It then enables the core and captures the packed result bytes after a fixed latency. Finally it unpacks the four 4-bit signed products and streams them out one per handshake. The block sits between a serial host interface and the multiplier core.

---
 rtl/matmul_stream_host.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/matmul_stream_host.sv
// Host-side stream adapter for the 2x2 signed matrix multiplier core.
// Loads eight 2-bit elements, runs the core for a fixed latency, then streams out four 4-bit products.
module matmul_stream_host #(
    parameter int unsigned RESULT_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_data,
    output logic [7:0] mm_a,
    output logic [7:0] mm_b,
    output logic       mm_ena,
    input  logic [7:0] mm_res_lo,
    input  logic [7:0] mm_res_hi,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic [1:0] out_idx,
    output logic       out_last,
    output logic       out_err
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned RES_W = 16;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   elem_cnt_q;
    logic [CNT_W-1:0]   wait_q;
    logic               err_q;
    logic [RES_W-1:0]   res_q;

    logic               in_hs;
    logic               out_hs;
    logic               elem_bad;
    logic               load_done;
    logic               capture;
    logic [1:0]         idx_next;

    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign elem_bad  = (in_data == 2'b10);
    assign load_done = in_hs && (elem_cnt_q == CNT_W'(7));
    assign capture   = (state_q == S_RUN) && (wait_q == CNT_W'(RESULT_LATENCY));
    assign idx_next  = out_idx + 2'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (load_done) begin
                    state_d = (err_q || elem_bad) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (capture) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_hs && out_last) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
        if (clear) begin
            state_d = S_LOAD;
        end
    end

    // Datapath and registered stream/core outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt_q <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
            res_q      <= '0;
            mm_a       <= '0;
            mm_b       <= '0;
            mm_ena     <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
        end else if (clear) begin
            elem_cnt_q <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
            mm_a       <= '0;
            mm_b       <= '0;
            mm_ena     <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            in_ready  <= (state_d == S_LOAD);
            out_valid <= (state_d == S_DRAIN);
            mm_ena    <= (state_d == S_RUN);
            case (state_q)
                S_LOAD: begin
                    wait_q <= '0;
                    if (in_hs) begin
                        if (!elem_cnt_q[2]) begin
                            mm_a[{elem_cnt_q[1:0], 1'b0} +: 2] <= in_data;
                        end else begin
                            mm_b[{elem_cnt_q[1:0], 1'b0} +: 2] <= in_data;
                        end
                        elem_cnt_q <= elem_cnt_q + CNT_W'(1);
                        err_q      <= err_q | elem_bad;
                        // Bad job skips the core and drains forced-zero results
                        if (load_done && (err_q || elem_bad)) begin
                            res_q    <= '0;
                            out_data <= '0;
                            out_idx  <= '0;
                            out_last <= 1'b0;
                            out_err  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    wait_q <= wait_q + CNT_W'(1);
                    if (capture) begin
                        res_q    <= {mm_res_hi, mm_res_lo};
                        out_data <= mm_res_lo[3:0];
                        out_idx  <= '0;
                        out_last <= 1'b0;
                        out_err  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (out_hs) begin
                        if (out_last) begin
                            elem_cnt_q <= '0;
                            err_q      <= 1'b0;
                            out_data   <= '0;
                            out_idx    <= '0;
                            out_last   <= 1'b0;
                            out_err    <= 1'b0;
                        end else begin
                            out_data <= res_q[{idx_next, 2'b00} +: 4];
                            out_idx  <= idx_next;
                            out_last <= (idx_next == 2'd3);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
